conv_stream_src: RTL and testbench
==================================

# conv_stream_src

Stream transmitter for the convolution datapath's `x`/`f` input channels. Holds one filter vector and one input vector in internal single-port memories, loaded through a simple write port. On `start` it streams both vectors concurrently over valid/ready handshakes into the convolution unit, with optional pseudo-random valid gaps to exercise consumer stall handling. Sits between host/bench load logic and `x_data`/`f_data` of the convolution block.

## Interface

- `WIDTH`, 10, data word width for both channels
- `SIZE_X`, 112, words per x vector
- `SIZE_F`, 49, words per f vector
- `LOGSIZE_X`, `$clog2(SIZE_X)`, x address/counter width (localparam)
- `LOGSIZE_F`, `$clog2(SIZE_F)`, f address/counter width (localparam)

- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `ld_en`  in  1  write one word into selected memory this cycle
- `ld_sel`  in  1  0 = f memory, 1 = x memory
- `ld_addr`  in  LOGSIZE_X  word address; for f only low LOGSIZE_F bits used
- `ld_data`  in  WIDTH  word to store
- `start`  in  1  begin streaming both vectors
- `throttle_en`  in  1  enable LFSR-driven valid gaps
- `busy`  out  1  streaming in progress
- `done`  out  1  one-cycle pulse, both vectors fully transferred
- `x_data`  out  WIDTH signed  x word
- `x_valid`  out  1  x word presented
- `x_ready`  in  1  consumer accepts x
- `f_data`  out  WIDTH signed  f word
- `f_valid`  out  1  f word presented
- `f_ready`  in  1  consumer accepts f

## Operation

- Memories: synchronous write, synchronous read (1-cycle latency), one per channel. Contents not cleared by reset.
- Load: `ld_en` while `busy`=0 writes `ld_data` at `ld_addr`. `ld_en` while `busy`=1 ignored. Addresses >= SIZE_X (x) or >= SIZE_F (f) ignored.
- States: IDLE, RUN, FIN.
  - IDLE: `start`=1 -> RUN; clear both send counters; `busy`<=1.
  - RUN: each channel independent; sends addresses 0..SIZE-1 in order. Handshake completes on an edge where `valid && ready`. When both counters reach SIZE -> FIN.
  - FIN: one cycle; `done`=1, `busy`=0; -> IDLE.
- `start` ignored outside IDLE.
- Handshake rules: once `valid` asserted it stays high with `data` unchanged until accepted. `valid` never depends combinationally on `ready`. After last word of a channel accepted, its `valid` stays 0 until next run.
- Throughput: with `ready` held high and `throttle_en`=0, one word per cycle per channel (prefetch/skid register required to hide memory latency).
- Throttle: 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances every cycle regardless of state. When `throttle_en`=1 and `lfsr[0]`=1, neither channel may raise `valid` for a new word that cycle; an already-asserted `valid` is never dropped.
- Simultaneous `ld_en` and `start` in IDLE: load performed, run starts; the new word is the one transmitted.

## Timing

- Reset values: `busy`=0, `done`=0, `x_valid`=0, `f_valid`=0, `x_data`=0, `f_data`=0, state IDLE, counters 0, LFSR 16'hACE1.
- `start` sampled at edge t -> `busy`=1 after t; first `x_valid`/`f_valid`=1 after edge t+1 (unthrottled).
- Unthrottled, always-ready: f completes SIZE_F cycles after first valid; x completes SIZE_X cycles after first valid; `done` high the cycle after the final x handshake, `busy` falls with it.
- Reset asserted mid-run: all outputs return to reset values immediately (asynchronous); memory contents retained; no `done`.

## Test plan

- Load x[i]=i, f[i]=-i; start; ready always 1, throttle off -> f words 0,-1..-48 on 49 consecutive cycles, x 0..111 on 112 consecutive cycles; `done` one cycle after last x; total 114 cycles start-to-done.
- Same data, `x_ready` toggling 1,0,1,0 -> x_data held stable through each 0 cycle; all 112 values in order; no duplicates or drops.
- `throttle_en`=1, ready=1 -> valid gaps occur, valid never falls while unaccepted; sequence still 0..111 / 0..-48; one `done`.
- `ld_en` and second `start` during RUN -> ignored; memory unchanged; next run re-sends original data.
- Assert `reset_n`=0 at x word 50 -> valids/busy 0 immediately; after release, start resends from word 0.
- `ld_addr`=112 with `ld_sel`=1 -> no write; x[0] unaffected (value 0 streamed first).

Source files
------------

// File: rtl/conv_stream_src_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_stream_src_if                                        |
// | Purpose  : x/f valid-ready stream bundle between the vector source   |
// |            and the convolution unit.                                 |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface conv_stream_src_if #(
  parameter int WIDTH = 10
);
  logic signed [WIDTH-1:0] x_data;
  logic                    x_valid;
  logic                    x_ready;
  logic signed [WIDTH-1:0] f_data;
  logic                    f_valid;
  logic                    f_ready;

  modport master (
    output x_data, x_valid, f_data, f_valid,
    input  x_ready, f_ready
  );

  modport slave (
    input  x_data, x_valid, f_data, f_valid,
    output x_ready, f_ready
  );
endinterface
`default_nettype wire

// File: rtl/conv_stream_src.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : conv_stream_src (with helper conv_stream_chan)            |
// | Purpose  : Holds one x and one f vector in local memories and        |
// |            streams both concurrently over valid/ready on start,      |
// |            with optional LFSR-driven valid gaps.                     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+

// One streaming channel: word memory, prefetch register and output stage.
// The prefetch register holds the memory read result so that the output
// stage can be refilled on every accepted word, hiding the read latency.
module conv_stream_chan #(
  parameter  int WIDTH = 10,
  parameter  int SIZE  = 49,
  localparam int AW    = $clog2(SIZE),
  localparam int CW    = $clog2(SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic signed [WIDTH-1:0] wr_data_i,
  input  logic                    first_i,    // run is starting: fetch word 0 now
  input  logic                    run_i,
  input  logic                    gap_i,      // no new word may be presented this cycle
  input  logic                    ready_i,
  output logic signed [WIDTH-1:0] data_o,
  output logic                    valid_o,
  output logic                    all_sent_o  // last word accepted by the coming edge (or earlier)
);
  logic signed [WIDTH-1:0] mem_q [SIZE];
  logic signed [WIDTH-1:0] rdata_q;
  logic signed [WIDTH-1:0] data_q;
  logic                    valid_q;
  logic                    rd_v_q, rd_v_d;
  logic [CW-1:0]           fptr_q, fptr_d;
  logic [CW-1:0]           sent_q, sent_d;
  logic [AW-1:0]           raddr;
  logic                    re, pop, hs;

  // Handshake, refill and fetch decisions for this cycle.
  always_comb begin
    hs     = valid_q & ready_i;
    pop    = run_i & rd_v_q & (~valid_q | ready_i) & ~gap_i;
    re     = first_i | (run_i & (fptr_q != CW'(SIZE)) & (~rd_v_q | pop));
    raddr  = first_i ? '0 : fptr_q[AW-1:0];
    fptr_d = first_i ? CW'(1) : (re ? fptr_q + CW'(1) : fptr_q);
    rd_v_d = re | (rd_v_q & ~pop);
    sent_d = first_i ? '0 : (hs ? sent_q + CW'(1) : sent_q);
    all_sent_o = (sent_d == CW'(SIZE));
  end

  // Memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read, prefetch flag, pointers and the output stage.
  // A word written in the same cycle it is read is forwarded directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
      rd_v_q  <= 1'b0;
      fptr_q  <= '0;
      sent_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (re) begin
        rdata_q <= (wr_en_i && (wr_addr_i == raddr)) ? wr_data_i : mem_q[raddr];
      end
      rd_v_q <= rd_v_d;
      fptr_q <= fptr_d;
      sent_q <= sent_d;
      if (pop) begin
        data_q  <= rdata_q;
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
endmodule

module conv_stream_src #(
  parameter  int WIDTH     = 10,
  parameter  int SIZE_X    = 112,
  parameter  int SIZE_F    = 49,
  localparam int LOGSIZE_X = $clog2(SIZE_X),
  localparam int LOGSIZE_F = $clog2(SIZE_F)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ld_en,
  input  logic                 ld_sel,
  input  logic [LOGSIZE_X-1:0] ld_addr,
  input  logic [WIDTH-1:0]     ld_data,
  input  logic                 start,
  input  logic                 throttle_en,
  output logic                 busy,
  output logic                 done,
  conv_stream_src_if.master    st
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic            busy_q, done_q;
  logic [15:0]     lfsr_q;
  logic            run, first, gap, ld_ok, x_we, f_we, x_all, f_all;
  logic [LOGSIZE_F-1:0] f_addr;

  // Load gating, run control and throttle request.
  always_comb begin
    run    = (state_q == S_RUN);
    first  = (state_q == S_IDLE) & start;
    gap    = throttle_en & lfsr_q[0];
    ld_ok  = ld_en & ~busy_q;
    f_addr = ld_addr[LOGSIZE_F-1:0];
    x_we   = ld_ok &  ld_sel & ({1'b0, ld_addr} < (LOGSIZE_X+1)'(SIZE_X));
    f_we   = ld_ok & ~ld_sel & ({1'b0, f_addr}  < (LOGSIZE_F+1)'(SIZE_F));
  end

  conv_stream_chan #(.WIDTH(WIDTH), .SIZE(SIZE_X)) u_x (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (x_we),
    .wr_addr_i (ld_addr),
    .wr_data_i (ld_data),
    .first_i   (first),
    .run_i     (run),
    .gap_i     (gap),
    .ready_i   (st.x_ready),
    .data_o    (st.x_data),
    .valid_o   (st.x_valid),
    .all_sent_o(x_all)
  );

  conv_stream_chan #(.WIDTH(WIDTH), .SIZE(SIZE_F)) u_f (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (f_we),
    .wr_addr_i (f_addr),
    .wr_data_i (ld_data),
    .first_i   (first),
    .run_i     (run),
    .gap_i     (gap),
    .ready_i   (st.f_ready),
    .data_o    (st.f_data),
    .valid_o   (st.f_valid),
    .all_sent_o(f_all)
  );

  // Run sequencer; done rises on the edge of the final handshake so it is
  // visible in the very next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (x_all && f_all) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end
  end

  assign busy = busy_q;
  assign done = done_q;
endmodule
`default_nettype wire

// File: tb/tb_conv_stream_src.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_conv_stream_src                                        |
// | Purpose  : Directed self-checking bench for conv_stream_src.         |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_conv_stream_src;
  localparam int WIDTH  = 10;
  localparam int SIZE_X = 112;
  localparam int SIZE_F = 49;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ld_en = 1'b0;
  logic       ld_sel = 1'b0;
  logic [6:0] ld_addr = '0;
  logic [9:0] ld_data = '0;
  logic       start = 1'b0;
  logic       throttle_en = 1'b0;
  logic       busy, done;

  conv_stream_src_if #(.WIDTH(WIDTH)) st ();

  conv_stream_src #(.WIDTH(WIDTH), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ld_en      (ld_en),
    .ld_sel     (ld_sel),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .start      (start),
    .throttle_en(throttle_en),
    .busy       (busy),
    .done       (done),
    .st         (st)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int mx [SIZE_X];
  int mf [SIZE_F];

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic sel, input int addr, input int data);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_addr = 7'(addr);
    ld_data = 10'(data);
    @(posedge clk); @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // One complete run; entered and left at a negedge with the DUT idle.
  task automatic run_stream(input string tag, input bit xtog, input bit thr,
                            input bit poke, input bit ldst, input bit tim);
    int xq[$];
    int fq[$];
    int cyc, ndone, done_cyc, first_xv, x_first, x_last, f_first, f_last;
    int unstable, gaps, xd, fd, pxd, pfd;
    bit xv, fv, xacc, facc, pxv, pxacc, pfv, pfacc;
    ndone = 0; done_cyc = -1; first_xv = -1;
    x_first = -1; x_last = -1; f_first = -1; f_last = -1;
    unstable = 0; gaps = 0; pxv = 0; pxacc = 0; pfv = 0; pfacc = 0; pxd = 0; pfd = 0;
    throttle_en = thr; st.x_ready = 1'b1; st.f_ready = 1'b1; start = 1'b1;
    if (ldst) begin
      ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 7'd0; ld_data = 10'd5; mx[0] = 5;
    end
    @(posedge clk); @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    cyc = 1;
    chk_val({tag, "_busy_after_start"}, int'(busy), 1);
    while (cyc < 1000 && !(done_cyc > 0 && cyc > done_cyc + 3)) begin
      xv = st.x_valid; fv = st.f_valid;
      xd = int'(st.x_data); fd = int'(st.f_data);
      if (pxv && !pxacc && (!xv || xd != pxd)) unstable++;
      if (pfv && !pfacc && (!fv || fd != pfd)) unstable++;
      if (busy && cyc >= 2 && !xv && xq.size() < SIZE_X) gaps++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        chk_val({tag, "_busy_at_done"}, int'(busy), 0);
      end
      if (first_xv < 0 && xv) first_xv = cyc;
      st.x_ready = xtog ? ((cyc % 2) == 1) : 1'b1;
      if (poke && cyc == 10) begin
        ld_en = 1'b1; ld_sel = 1'b1; ld_addr = 7'd3; ld_data = 10'd500; start = 1'b1;
      end else begin
        ld_en = 1'b0; start = 1'b0;
      end
      xacc = xv && st.x_ready;
      facc = fv && st.f_ready;
      if (xacc) begin
        xq.push_back(xd);
        if (x_first < 0) x_first = cyc;
        x_last = cyc;
      end
      if (facc) begin
        fq.push_back(fd);
        if (f_first < 0) f_first = cyc;
        f_last = cyc;
      end
      pxv = xv; pxacc = xacc; pxd = xd;
      pfv = fv; pfacc = facc; pfd = fd;
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    ld_en = 1'b0; start = 1'b0; st.x_ready = 1'b1; throttle_en = 1'b0;
    chk_val({tag, "_x_count"}, xq.size(), SIZE_X);
    chk_val({tag, "_f_count"}, fq.size(), SIZE_F);
    for (int i = 0; i < SIZE_X; i++)
      chk_val($sformatf("%s_x[%0d]", tag, i), (i < xq.size()) ? xq[i] : -9999, mx[i]);
    for (int i = 0; i < SIZE_F; i++)
      chk_val($sformatf("%s_f[%0d]", tag, i), (i < fq.size()) ? fq[i] : -9999, mf[i]);
    chk_val({tag, "_done_pulses"}, ndone, 1);
    chk_val({tag, "_valid_held"}, unstable, 0);
    if (thr) chk_val({tag, "_gaps_seen"}, int'(gaps > 0), 1);
    if (tim) begin
      chk_val({tag, "_first_valid_cyc"}, first_xv, 2);
      chk_val({tag, "_done_cyc"}, done_cyc, 114);
      chk_val({tag, "_x_span"}, x_last - x_first, SIZE_X - 1);
      chk_val({tag, "_f_span"}, f_last - f_first, SIZE_F - 1);
      chk_val({tag, "_f_first"}, f_first, 2);
      chk_val({tag, "_no_gaps"}, gaps, 0);
    end
  endtask

  task automatic reset_mid_run();
    int cyc;
    bit hit;
    cyc = 0; hit = 0;
    st.x_ready = 1'b1; st.f_ready = 1'b1; throttle_en = 1'b0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    while (!hit && cyc < 300) begin
      if (st.x_valid && int'(st.x_data) == 50) hit = 1;
      else begin
        @(posedge clk); @(negedge clk);
        cyc++;
      end
    end
    chk_val("rst_reached_word50", int'(hit), 1);
    reset_n = 1'b0;
    #1;
    chk_val("rst_x_valid", int'(st.x_valid), 0);
    chk_val("rst_f_valid", int'(st.f_valid), 0);
    chk_val("rst_busy", int'(busy), 0);
    chk_val("rst_done", int'(done), 0);
    chk_val("rst_x_data", int'(st.x_data), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_val("rst_busy_after_release", int'(busy), 0);
  endtask

  initial begin
    st.x_ready = 1'b1;
    st.f_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_val("reset_busy", int'(busy), 0);
    chk_val("reset_done", int'(done), 0);
    chk_val("reset_x_valid", int'(st.x_valid), 0);
    chk_val("reset_f_valid", int'(st.f_valid), 0);
    chk_val("reset_x_data", int'(st.x_data), 0);
    chk_val("reset_f_data", int'(st.f_data), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < SIZE_X; i++) begin
      load_word(1'b1, i, i);
      mx[i] = i;
    end
    for (int i = 0; i < SIZE_F; i++) begin
      load_word(1'b0, i, -i);
      mf[i] = -i;
    end
    // Out-of-range x address must not disturb any stored word.
    load_word(1'b1, 112, 77);

    run_stream("r1_plain",    1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_stream("r2_xtoggle",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_stream("r3_throttle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream("r4_poke",     1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_stream("r5_resend",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_mid_run();
    run_stream("r6_after_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_stream("r7_ld_start",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
